// File: rtl/ps2_kbd_pkg.sv
// Shared constants, prefix-FSM state type and the set-2 scan-code to ASCII lookup
// for the PS/2 keyboard path.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} kbd_state_e;

  // Returns {hit, ascii}. Upper selects capitals for letters only.
  function automatic logic [8:0] scan_to_ascii(input logic [7:0] code, input logic upper);
    logic [7:0] a;
    logic       hit;
    a   = 8'h00;
    hit = 1'b1;
    case (code)
      8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
      8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
      8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
      8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
      8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
      8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
      8'h35: a = "y";  8'h1A: a = "z";
      8'h45: a = "0";  8'h16: a = "1";  8'h1E: a = "2";  8'h26: a = "3";
      8'h25: a = "4";  8'h2E: a = "5";  8'h36: a = "6";  8'h3D: a = "7";
      8'h3E: a = "8";  8'h46: a = "9";
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      8'h66: a = 8'h08;
      default: hit = 1'b0;
    endcase
    if (upper && (a >= "a") && (a <= "z")) a = a - 8'h20;
    return {hit, a};
  endfunction

endpackage

// File: rtl/kbd_sync_fifo.sv
// First-word-fall-through synchronous FIFO. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; dout holds the last popped word when empty.
module kbd_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = mem_q[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scan-code to ASCII decoder with prefix FSM, shift tracking and output FIFO.
// Optional caps-lock handling is built when PS2_CAPS_LOCK_EN is defined.
module ps2_ascii_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             scan_valid,
  input  logic [7:0]       scan_code,
  input  logic             letter_case,
  input  logic             out_ready,
  output logic             ascii_valid,
  output logic [7:0]       ascii_code,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow,
  input  logic             overflow_clr
);

  kbd_state_e state_q, state_d;
  logic       lshift_q, lshift_d, rshift_q, rshift_d;
  logic       overflow_q, overflow_d;
  logic       make_vld, brk_vld, is_mod, upper, push, full, empty, drop;
  logic [8:0] lut;

`ifdef PS2_CAPS_LOCK_EN
  logic caps_q, caps_d, caps_held_q, caps_held_d;
`endif

  always_comb begin
    state_d  = state_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    make_vld = 1'b0;
    brk_vld  = 1'b0;
    if (scan_valid) begin
      case (state_q)
        IDLE: begin
          if (scan_code == SC_EXT)        state_d = EXT;
          else if (scan_code == SC_BREAK) state_d = BRK;
          else                            make_vld = 1'b1;
        end
        EXT: begin
          if (scan_code == SC_BREAK)   state_d = EXT_BRK;
          else if (scan_code != SC_EXT) state_d = IDLE;
        end
        BRK: begin
          if (scan_code != SC_EXT && scan_code != SC_BREAK) begin
            state_d = IDLE;
            brk_vld = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (make_vld && scan_code == SC_LSHIFT) lshift_d = 1'b1;
    if (make_vld && scan_code == SC_RSHIFT) rshift_d = 1'b1;
    if (brk_vld && scan_code == SC_LSHIFT)  lshift_d = 1'b0;
    if (brk_vld && scan_code == SC_RSHIFT)  rshift_d = 1'b0;
  end

`ifdef PS2_CAPS_LOCK_EN
  // Toggle only on the first make so typematic repeats of caps lock are ignored.
  always_comb begin
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    if (make_vld && scan_code == SC_CAPS) begin
      caps_held_d = 1'b1;
      if (!caps_held_q) caps_d = ~caps_q;
    end
    if (brk_vld && scan_code == SC_CAPS) caps_held_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
    end else begin
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
    end
  end

  assign upper  = letter_case ^ (lshift_q | rshift_q) ^ caps_q;
  assign is_mod = (scan_code == SC_LSHIFT) || (scan_code == SC_RSHIFT) || (scan_code == SC_CAPS);
`else
  assign upper  = letter_case ^ (lshift_q | rshift_q);
  assign is_mod = (scan_code == SC_LSHIFT) || (scan_code == SC_RSHIFT);
`endif

  assign lut  = scan_to_ascii(scan_code, upper);
  assign push = make_vld && !is_mod && lut[8];
  // Full implies non-empty, so only out_ready decides whether the push fits.
  assign drop = push && full && !out_ready;

  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clr) overflow_d = 1'b0;
    if (drop)         overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      lshift_q   <= 1'b0;
      rshift_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lshift_q   <= lshift_d;
      rshift_q   <= rshift_d;
      overflow_q <= overflow_d;
    end
  end

  kbd_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (lut[7:0]),
    .pop    (out_ready),
    .dout   (ascii_code),
    .full   (full),
    .empty  (empty),
    .count  (fifo_count)
  );

  assign ascii_valid = !empty;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Scoreboard bench for ps2_ascii_decoder: expected characters are queued as scan
// bytes are driven and compared as the DUT hands them to the consumer.
module tb_ps2_ascii_decoder;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             resetn, scan_valid, letter_case, out_ready, overflow_clr;
  logic [7:0]       scan_code;
  logic             ascii_valid, overflow;
  logic [7:0]       ascii_code;
  logic [CNT_W-1:0] fifo_count;

  logic [7:0] sb_q [$];
  int         n_cmp = 0;
  int         n_err = 0;

  ps2_ascii_decoder #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .scan_valid   (scan_valid),
    .scan_code    (scan_code),
    .letter_case  (letter_case),
    .out_ready    (out_ready),
    .ascii_valid  (ascii_valid),
    .ascii_code   (ascii_code),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    @(posedge clk); #1;
    scan_valid = 1'b1;
    scan_code  = c;
    @(posedge clk); #1;
    scan_valid = 1'b0;
  endtask

  task automatic send_exp(input logic [7:0] c, input logic [7:0] e);
    sb_q.push_back(e);
    send(c);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || ascii_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", (n < 100), 1);
  endtask

  // Consumer side: a pop happens on the next rising edge.
  always @(negedge clk) begin
    if (resetn && ascii_valid && out_ready) begin
      chk("sb_nonempty", (sb_q.size() > 0), 1);
      if (sb_q.size() > 0) chk("ascii", ascii_code, sb_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; scan_valid = 1'b0; scan_code = 8'h00;
    letter_case = 1'b0; out_ready = 1'b0; overflow_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", ascii_valid, 0);
    chk("rst_code", ascii_code, 8'h00);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    resetn = 1'b1;

    // First make: visible the cycle after the strobe; break adds nothing.
    out_ready = 1'b1;
    send_exp(8'h1C, 8'h61);
    chk("lat_valid", ascii_valid, 1);
    chk("lat_code", ascii_code, 8'h61);
    send(8'hF0); send(8'h1C);
    drain();
    chk("brk_count", fifo_count, 0);

    // Shift tracking under both letter_case settings.
    send(8'h12); send_exp(8'h1C, 8'h41); send(8'hF0); send(8'h12); send_exp(8'h1C, 8'h61);
    letter_case = 1'b1;
    send(8'h12); send_exp(8'h1C, 8'h61); send(8'hF0); send(8'h12); send_exp(8'h1C, 8'h41);
    letter_case = 1'b0;
    drain();

    // Extended make/break and unmapped code are silent; FSM back in IDLE.
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h07);
    repeat (3) @(posedge clk);
    #1;
    chk("ext_count", fifo_count, 0);
    chk("ext_valid", ascii_valid, 0);
    send_exp(8'h1C, 8'h61);
    drain();

    // Case-independent codes under right shift, plus typematic repeat.
    send(8'h59);
    send_exp(8'h45, 8'h30); send_exp(8'h46, 8'h39); send_exp(8'h29, 8'h20);
    send_exp(8'h5A, 8'h0D); send_exp(8'h66, 8'h08); send_exp(8'h1A, 8'h5A);
    send(8'hF0); send(8'h59);
    send_exp(8'h1A, 8'h7A); send_exp(8'h1A, 8'h7A);
    drain();

    // Overflow: five makes into a four-entry FIFO with the consumer stalled.
    out_ready = 1'b0;
    send_exp(8'h1C, 8'h61); send_exp(8'h32, 8'h62); send_exp(8'h21, 8'h63);
    send_exp(8'h23, 8'h64); send(8'h24);
    chk("full_count", fifo_count, 4);
    chk("full_ovf", overflow, 1);
    chk("full_head", ascii_code, 8'h61);
    @(posedge clk); #1 overflow_clr = 1'b1;
    @(posedge clk); #1 overflow_clr = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Push and pop on a full FIFO in the same cycle.
    @(posedge clk); #1;
    sb_q.push_back(8'h66);
    scan_valid = 1'b1; scan_code = 8'h2B; out_ready = 1'b1;
    @(posedge clk); #1;
    scan_valid = 1'b0; out_ready = 1'b0;
    chk("fullpop_count", fifo_count, 4);
    chk("fullpop_ovf", overflow, 0);

    // A drop in the same cycle as a clear keeps overflow set.
    @(posedge clk); #1;
    scan_valid = 1'b1; scan_code = 8'h2C; overflow_clr = 1'b1;
    @(posedge clk); #1;
    scan_valid = 1'b0; overflow_clr = 1'b0;
    chk("clr_vs_drop", overflow, 1);

    out_ready = 1'b1;
    drain();
    chk("empty_count", fifo_count, 0);
    chk("empty_hold", ascii_code, 8'h66);
    @(posedge clk); #1 overflow_clr = 1'b1;
    @(posedge clk); #1 overflow_clr = 1'b0;

`ifdef PS2_CAPS_LOCK_EN
    send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    send_exp(8'h1D, 8'h57);
    send_exp(8'h45, 8'h30);
    send(8'h58); send(8'hF0); send(8'h58);
    send_exp(8'h1D, 8'h77);
`else
    send(8'h58); send(8'hF0); send(8'h58);
    send_exp(8'h1D, 8'h77);
`endif
    drain();

    // Reset in the middle of a shift+break sequence clears FSM and shift.
    send(8'h12); send(8'hF0);
    @(posedge clk); #1 resetn = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    chk("midrst_count", fifo_count, 0);
    send_exp(8'h1C, 8'h61);
    drain();
    chk("sb_empty_end", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
